jk_bank_driver: RTL and testbench



---
 rtl/jk_bank_driver.sv | 93 +++++++++
 tb/tb_jk_bank_driver.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: steers a bank of external JK flip-flops to requested targets
// using a shadow copy of the bank, then verifies the fed-back Q.
module jk_bank_driver #(
    parameter int WIDTH      = 4,
    parameter bit USE_TOGGLE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             mismatch,
    output logic [7:0]       err_cnt
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d, exp_q, exp_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic [WIDTH-1:0] chg, exc_j, exc_k;
    logic             done_q, done_d, mis_q, mis_d;
    logic [7:0]       err_q, err_d;

    assign chg   = shadow_q ^ tgt_data;
    assign exc_j = USE_TOGGLE ? chg : chg & tgt_data;
    assign exc_k = USE_TOGGLE ? chg : chg & ~tgt_data;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        exp_d    = exp_q;
        j_d      = '0;
        k_d      = '0;
        done_d   = 1'b0;
        mis_d    = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: if (tgt_valid) begin
                j_d     = exc_j;
                k_d     = exc_k;
                exp_d   = tgt_data;
                state_d = DRIVE;
            end
            DRIVE: begin
                shadow_d = exp_q;
                state_d  = CHECK;
            end
            CHECK: begin
                done_d  = 1'b1;
                mis_d   = q_fb != shadow_q;
                // resync to the real bank so later excitation is correct
                if (mis_d) begin
                    shadow_d = q_fb;
                    err_d    = err_q + {7'd0, err_q != 8'hFF};
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            exp_q    <= '0;
            j_q      <= '0;
            k_q      <= '0;
            done_q   <= 1'b0;
            mis_q    <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            exp_q    <= exp_d;
            j_q      <= j_d;
            k_q      <= k_d;
            done_q   <= done_d;
            mis_q    <= mis_d;
            err_q    <= err_d;
        end
    end

    assign tgt_ready = state_q == IDLE;
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign mismatch  = mis_q;
    assign err_cnt   = err_q;
endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: checks set/reset and toggle drivers against behavioural JK banks.
module tb_jk_bank_driver;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] tgt_data;
    logic       tgt_valid;
    logic       rdy0, rdy1, done0, done1, mis0, mis1;
    logic [3:0] j0, k0, j1, k1, bq0, bq1, q_fb0, q_fb1, stuck0;
    logic [7:0] err0, err1;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [3:0] t, ej, ek, ejt, ekt, eq0, eq1;
    } vec_t;
    typedef struct {
        logic       mis;
        logic [7:0] err;
    } sb_t;
    sb_t  sb[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    jk_bank_driver #(.WIDTH(4), .USE_TOGGLE(1'b0)) dut (
        .clk(clk), .reset(reset), .tgt_data(tgt_data), .tgt_valid(tgt_valid),
        .tgt_ready(rdy0), .j(j0), .k(k0), .q_fb(q_fb0),
        .done(done0), .mismatch(mis0), .err_cnt(err0));

    jk_bank_driver #(.WIDTH(4), .USE_TOGGLE(1'b1)) dut_t (
        .clk(clk), .reset(reset), .tgt_data(tgt_data), .tgt_valid(tgt_valid),
        .tgt_ready(rdy1), .j(j1), .k(k1), .q_fb(q_fb1),
        .done(done1), .mismatch(mis1), .err_cnt(err1));

    // behavioural JK banks sharing the driver clock and reset
    always @(posedge clk) begin
        bq0 <= reset ? 4'b0 : (j0 & ~bq0) | (~k0 & bq0);
        bq1 <= reset ? 4'b0 : (j1 & ~bq1) | (~k1 & bq1);
    end
    assign q_fb0 = bq0 & ~stuck0;
    assign q_fb1 = bq1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (!reset && (done0 || done1 || mis0 || mis1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {done0, done1, mis0, mis1}, 8'h0);
            end else begin
                e = sb.pop_front();
                chk("done0", done0, 1);
                chk("done1", done1, 1);
                chk("mismatch0", mis0, e.mis);
                chk("mismatch1", mis1, 0);
                chk("err_cnt0", err0, e.err);
            end
        end
    end

    // entered just after a rising edge with the drivers in IDLE; leaves tgt_valid high
    task automatic run_target(input logic [3:0] t, ej, ek, ejt, ekt, eq0, eq1,
                              input logic emis, input logic [7:0] eerr, input logic abort);
        tgt_data  = t;
        tgt_valid = 1'b1;
        #1;
        chk("ready0_N", rdy0, 1);
        chk("ready1_N", rdy1, 1);
        sb.push_back('{emis, eerr});
        @(posedge clk); #1;
        tgt_data = ~t;
        chk("j0", j0, ej);
        chk("k0", k0, ek);
        chk("j1", j1, ejt);
        chk("k1", k1, ekt);
        chk("ready0_N1", rdy0, 0);
        if (abort) begin
            tgt_valid = 1'b0;
            reset     = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            sb.delete();
            chk("abort_j0", j0, 0);
            chk("abort_k0", k0, 0);
            chk("abort_ready0", rdy0, 1);
            chk("abort_done0", done0, 0);
            chk("abort_q0", q_fb0, 0);
            chk("abort_q1", q_fb1, 0);
            repeat (4) @(posedge clk);
            #1;
        end else begin
            @(posedge clk); #1;
            chk("j0_N2", j0, 0);
            chk("k0_N2", k0, 0);
            chk("jk1_N2", {j1, k1}, 0);
            chk("q0_N2", q_fb0, eq0);
            chk("q1_N2", q_fb1, eq1);
            @(posedge clk); #1;
            chk("ready0_N3", rdy0, 1);
            chk("ready1_N3", rdy1, 1);
        end
    endtask

    initial begin
        //            t        j0       k0       jt       kt       q0       q1
        tbl[0] = '{4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
        tbl[1] = '{4'b0110, 4'b0100, 4'b1000, 4'b1100, 4'b1100, 4'b0110, 4'b0110};
        tbl[2] = '{4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0110};
        tbl[3] = '{4'b1001, 4'b1001, 4'b0110, 4'b1111, 4'b1111, 4'b1001, 4'b1001};
        tbl[4] = '{4'b0000, 4'b0000, 4'b1001, 4'b1001, 4'b1001, 4'b0000, 4'b0000};
        tbl[5] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        tbl[6] = '{4'b0011, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0011, 4'b0011};
        tbl[7] = '{4'b0000, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
        reset     = 1'b1;
        tgt_valid = 1'b0;
        tgt_data  = 4'b0;
        stuck0    = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rdy0, 1);
        chk("rst_jk", {j0, k0}, 0);
        chk("rst_done", done0, 0);
        chk("rst_mismatch", mis0, 0);
        chk("rst_err", err0, 0);
        chk("rst_bank", q_fb0, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        // tgt_valid stays high across entries, so handshakes land 3 cycles apart
        for (int i = 0; i < 8; i++)
            run_target(tbl[i].t, tbl[i].ej, tbl[i].ek, tbl[i].ejt, tbl[i].ekt,
                       tbl[i].eq0, tbl[i].eq1, 1'b0, 8'd0, 1'b0);
        // bit 0 of the first bank stuck at 0
        stuck0 = 4'b0001;
        run_target(4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 8'd1, 1'b0);
        run_target(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 8'd2, 1'b0);
        for (int i = 3; i <= 300; i++)
            run_target(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
                       1'b1, (i > 255) ? 8'd255 : 8'(i), 1'b0);
        stuck0 = 4'b0;
        run_target(4'b1111, 4'b1111, 4'b0000, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 1'b0, 8'd0, 1'b1);
        chk("abort_err_cleared", err0, 0);
        run_target(4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b0, 8'd0, 1'b0);
        tgt_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pending_done", 8'(sb.size()), 0);
        chk("final_ready", rdy0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
